// File: rtl/xillybus_spi_pkg.sv
// rtl/xillybus_spi_pkg.sv - shared constants and FSM encoding for the Xillybus SPI bridge
// Contents:
//   TX_LSB/TX_MSB  tx byte field of a command word
//   KEEP_CS_BIT    command bit that keeps chip select low after the byte
//   RESP_PAD_W     zero padding above the rx byte in a response word
//   spi_state_e    engine states
package xillybus_spi_pkg;

  localparam int TX_LSB      = 0;
  localparam int TX_MSB      = 7;
  localparam int KEEP_CS_BIT = 8;
  localparam int RESP_PAD_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/xillybus_spi_resp_fifo.sv
// rtl/xillybus_spi_resp_fifo.sv - synchronous response FIFO with flush and registered empty
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       synchronous clear of contents and read data
//   push_i        write push_data_i (dropped only if full without a pop)
//   pop_i         read strobe; pop_data_o valid next cycle, ignored when empty
//   empty_o       registered empty flag
//   count_o       current occupancy
module xillybus_spi_resp_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q;
  logic [7:0]    rdata_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      rdata_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      rdata_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rdata_q  <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  assign pop_data_o = rdata_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;

endmodule

// File: rtl/xillybus_spi_bridge.sv
// rtl/xillybus_spi_bridge.sv - byte-oriented SPI master between Xillybus write_spi/read_spi streams
// Ports:
//   bus_clk, bus_reset_n         clock, asynchronous active-low reset
//   quiesce                      synchronous abort and flush
//   user_w_write_spi_*           command stream: [7:0] tx byte, [8] keep_cs
//   user_r_read_spi_*            response stream: {24'h0, rx byte}
//   spi_sclk/mosi/miso/cs_n      SPI mode 0 bus
module xillybus_spi_bridge
  import xillybus_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int RESP_DEPTH = 16
) (
  input  logic        bus_clk,
  input  logic        bus_reset_n,
  input  logic        quiesce,
  input  logic        user_w_write_spi_wren,
  input  logic [31:0] user_w_write_spi_data,
  output logic        user_w_write_spi_full,
  input  logic        user_w_write_spi_open,
  input  logic        user_r_read_spi_rden,
  output logic [31:0] user_r_read_spi_data,
  output logic        user_r_read_spi_empty,
  output logic        user_r_read_spi_eof,
  input  logic        user_r_read_spi_open,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

  spi_state_e             state_q, state_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [KEEP_CS_BIT:0]   buf_data_q, buf_data_d;
  logic                   full_q, full_d;
  logic [7:0]             tx_q, tx_d, rx_q, rx_d;
  logic                   keep_q, keep_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             bit_q, bit_d;
  logic                   sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic                   push_q, push_d, eof_q, eof_d;

  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty, room, div_end, load;
  logic [7:0]             fifo_rdata;
  logic                   cmd_unused;

  assign cmd_unused = ^user_w_write_spi_data[31:KEEP_CS_BIT+1];
  assign div_end    = (div_q == DIV_LAST);
  assign load       = user_w_write_spi_wren && !full_q;
  // A push still in flight (push_q) will occupy a slot next cycle.
  assign room = push_q ? (fifo_count < CNT_W'(RESP_DEPTH - 1))
                       : (fifo_count < CNT_W'(RESP_DEPTH));

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    keep_d      = keep_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    push_d      = 1'b0;

    if (load) begin
      buf_valid_d = 1'b1;
      buf_data_d  = user_w_write_spi_data[KEEP_CS_BIT:TX_LSB];
    end

    case (state_q)
      ST_IDLE: begin
        if (buf_valid_q && room) begin
          state_d     = ST_SETUP;
          buf_valid_d = 1'b0;
          tx_d        = buf_data_q[TX_MSB:TX_LSB];
          keep_d      = buf_data_q[KEEP_CS_BIT];
          mosi_d      = buf_data_q[TX_MSB];
          cs_n_d      = 1'b0;
          div_d       = '0;
        end
      end
      ST_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], spi_miso};
        end
      end
      ST_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end else if (bit_q == 4'd8) begin
            push_d  = 1'b1;
            state_d = keep_q ? ST_GAP : ST_HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end
        end
      end
      ST_GAP: begin
        if (buf_valid_q && room) begin
          // Skip SETUP: preload one cycle of low phase so mosi leads the rise.
          state_d     = ST_SHIFT;
          buf_valid_d = 1'b0;
          tx_d        = buf_data_q[TX_MSB:TX_LSB];
          keep_d      = buf_data_q[KEEP_CS_BIT];
          mosi_d      = buf_data_q[TX_MSB];
          div_d       = DIV_LAST;
          bit_d       = '0;
        end else if (!user_w_write_spi_open) begin
          state_d = ST_HOLD;
          div_d   = '0;
        end
      end
      ST_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          state_d = ST_IDLE;
          div_d   = '0;
          cs_n_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (quiesce) begin
      state_d     = ST_IDLE;
      buf_valid_d = 1'b0;
      div_d       = '0;
      bit_d       = '0;
      sclk_d      = 1'b0;
      mosi_d      = 1'b0;
      cs_n_d      = 1'b1;
      push_d      = 1'b0;
    end

    full_d = quiesce | buf_valid_d;
    eof_d  = !quiesce && user_r_read_spi_open && !user_w_write_spi_open &&
             !buf_valid_q && (state_q == ST_IDLE) && fifo_empty;
  end

  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      full_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      keep_q      <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      push_q      <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      full_q      <= full_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      keep_q      <= keep_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      push_q      <= push_d;
      eof_q       <= eof_d;
    end
  end

  xillybus_spi_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (bus_clk),
    .rst_n       (bus_reset_n),
    .flush_i     (quiesce || !user_r_read_spi_open),
    .push_i      (push_q),
    .push_data_i (rx_q),
    .pop_i       (user_r_read_spi_rden),
    .pop_data_o  (fifo_rdata),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign user_w_write_spi_full = full_q;
  assign user_r_read_spi_data  = {{RESP_PAD_W{1'b0}}, fifo_rdata};
  assign user_r_read_spi_empty = fifo_empty;
  assign user_r_read_spi_eof   = eof_q;
  assign spi_sclk              = sclk_q;
  assign spi_mosi              = mosi_q;
  assign spi_cs_n              = cs_n_q;

endmodule

// File: tb/tb_xillybus_spi_bridge.sv
// tb/tb_xillybus_spi_bridge.sv - directed self-checking bench for xillybus_spi_bridge
module tb_xillybus_spi_bridge;

  localparam int CD    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        quiesce = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] wdata = '0;
  logic        wfull;
  logic        wopen = 1'b1;
  logic        rden = 1'b0;
  logic [31:0] rdata;
  logic        rempty;
  logic        reof;
  logic        ropen = 1'b1;
  logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;

  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  int cs_rise_cnt = 0;
  int cnt;
  logic [7:0] mosi_cap = '0;

  always #5 clk = ~clk;

  assign spi_miso = spi_mosi;

  always @(posedge spi_sclk) begin
    rise_cnt = rise_cnt + 1;
    mosi_cap = {mosi_cap[6:0], spi_mosi};
  end

  always @(posedge spi_cs_n) cs_rise_cnt = cs_rise_cnt + 1;

  xillybus_spi_bridge #(
    .CLK_DIV    (CD),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .bus_clk               (clk),
    .bus_reset_n           (rst_n),
    .quiesce               (quiesce),
    .user_w_write_spi_wren (wren),
    .user_w_write_spi_data (wdata),
    .user_w_write_spi_full (wfull),
    .user_w_write_spi_open (wopen),
    .user_r_read_spi_rden  (rden),
    .user_r_read_spi_data  (rdata),
    .user_r_read_spi_empty (rempty),
    .user_r_read_spi_eof   (reof),
    .user_r_read_spi_open  (ropen),
    .spi_sclk              (spi_sclk),
    .spi_mosi              (spi_mosi),
    .spi_miso              (spi_miso),
    .spi_cs_n              (spi_cs_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    wren  = 1'b1;
    wdata = w;
    tick();
    wren  = 1'b0;
  endtask

  task automatic send(input string tag, input logic [31:0] w);
    int n;
    for (n = 0; n < 200 && wfull !== 1'b0; n++) tick();
    check(tag, 32'(n < 200), 32'd1);
    write_word(w);
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset values
    ticks(2);
    check("rst_full", wfull, 0);
    check("rst_empty", rempty, 1);
    check("rst_eof", reof, 0);
    check("rst_data", rdata, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 1);
    rst_n = 1'b1;
    ticks(2);

    // Mode/timing: single byte 0x81, keep_cs=0
    rise_cnt = 0;
    write_word(32'h0000_0081);                 // now N+1
    check("t_full_n1", wfull, 1);
    check("t_cs_n1", spi_cs_n, 1);
    tick();                                    // N+2
    check("t_full_n2", wfull, 0);
    check("t_cs_n2", spi_cs_n, 0);
    check("t_mosi_msb", spi_mosi, 1);
    tick();                                    // N+3
    check("t_sclk_n3", spi_sclk, 0);
    tick();                                    // N+4 first rise
    check("t_sclk_rise1", spi_sclk, 1);
    check("t_rise1_cnt", rise_cnt, 1);
    ticks(CD);                                 // N+6 first fall
    check("t_sclk_fall1", spi_sclk, 0);
    check("t_mosi_bit6", spi_mosi, 0);
    ticks(CD);                                 // N+8 second rise
    check("t_sclk_rise2", spi_sclk, 1);
    ticks(28);                                 // N+36 push cycle
    check("t_empty_push", rempty, 1);
    check("t_sclk_push", spi_sclk, 0);
    tick();                                    // N+37
    check("t_empty_after", rempty, 0);
    check("t_rises", rise_cnt, 8);
    check("t_mosi_bits", mosi_cap, 8'h81);
    check("t_cs_hold", spi_cs_n, 0);
    tick();                                    // N+38
    check("t_cs_release", spi_cs_n, 1);
    read_word("t_rd", 32'h0000_0081);
    check("t_rd_empty", rempty, 1);

    // Loopback, two bytes with keep_cs on the first
    ticks(3);
    rise_cnt = 0;
    cs_rise_cnt = 0;
    write_word(32'h0000_01A5);                 // N+1
    tick();                                    // N+2
    write_word(32'h0000_003C);                 // N+3
    check("lb_cs_low", spi_cs_n, 0);
    for (cnt = 0; cnt < 300 && spi_cs_n !== 1'b1; cnt++) tick();
    check("lb_cs_rise_cycle", cnt, 69);
    check("lb_cs_rises", cs_rise_cnt, 1);
    check("lb_sclk_rises", rise_cnt, 16);
    read_word("lb_rd0", 32'h0000_00A5);
    read_word("lb_rd1", 32'h0000_003C);
    check("lb_empty", rempty, 1);

    // Full drop: two consecutive wren cycles
    ticks(3);
    rise_cnt = 0;
    wren = 1'b1;
    wdata = 32'h0000_0011;
    tick();
    check("fd_full", wfull, 1);
    wdata = 32'h0000_0022;
    tick();
    wren = 1'b0;
    for (cnt = 0; cnt < 200 && rempty !== 1'b0; cnt++) tick();
    check("fd_pushed", rempty, 0);
    ticks(60);
    check("fd_rises", rise_cnt, 8);
    check("fd_cs_idle", spi_cs_n, 1);
    read_word("fd_rd", 32'h0000_0011);
    check("fd_empty", rempty, 1);

    // Backpressure: five words into a 4-deep response FIFO, no reads
    ticks(3);
    rise_cnt = 0;
    for (int k = 1; k <= 5; k++) send("bp_send", 32'(k));
    ticks(150);
    check("bp_rises", rise_cnt, 32);
    check("bp_full", wfull, 1);
    check("bp_cs_idle", spi_cs_n, 1);
    write_word(32'h0000_0006);                 // dropped while full
    tick();
    read_word("bp_rd1", 32'h0000_0001);        // M+1
    tick();                                    // M+2
    check("bp_restart", spi_cs_n, 0);
    ticks(60);
    check("bp_full_after", wfull, 0);
    read_word("bp_rd2", 32'h0000_0002);
    read_word("bp_rd3", 32'h0000_0003);
    read_word("bp_rd4", 32'h0000_0004);
    read_word("bp_rd5", 32'h0000_0005);
    check("bp_empty", rempty, 1);
    check("bp_rises_total", rise_cnt, 40);

    // EOF
    ticks(3);
    send("eof_send", 32'h0000_0055);
    wopen = 1'b0;
    ticks(60);
    check("eof_wait", reof, 0);
    check("eof_nonempty", rempty, 0);
    read_word("eof_rd", 32'h0000_0055);        // M+1
    check("eof_m1", reof, 0);
    tick();                                    // M+2
    check("eof_set", reof, 1);
    wopen = 1'b1;
    tick();
    check("eof_clear", reof, 0);

    // keep_cs byte closed by write_open falling
    send("gap_send", 32'h0000_01AA);
    for (cnt = 0; cnt < 200 && rempty !== 1'b0; cnt++) tick();
    check("gap_pushed", rempty, 0);
    ticks(5);
    check("gap_cs_low", spi_cs_n, 0);
    wopen = 1'b0;                              // cycle G
    ticks(2);                                  // G+2
    check("gap_hold", spi_cs_n, 0);
    tick();                                    // G+3
    check("gap_release", spi_cs_n, 1);
    read_word("gap_rd", 32'h0000_00AA);
    wopen = 1'b1;

    // Quiesce during bit 3 with one response already queued
    ticks(3);
    send("q_pre", 32'h0000_0077);
    ticks(50);
    check("q_pre_queued", rempty, 0);
    write_word(32'h0000_00F0);                 // N+1
    ticks(15);                                 // N+16
    check("q_sclk_bit3", spi_sclk, 1);
    check("q_cs_bit3", spi_cs_n, 0);
    quiesce = 1'b1;
    tick();
    check("q_sclk", spi_sclk, 0);
    check("q_cs_n", spi_cs_n, 1);
    check("q_mosi", spi_mosi, 0);
    check("q_full", wfull, 1);
    check("q_empty", rempty, 1);
    tick();
    quiesce = 1'b0;
    tick();
    check("q_full_clear", wfull, 0);
    send("q_post", 32'h0000_003C);
    ticks(60);
    read_word("q_post_rd", 32'h0000_003C);

    // Asynchronous reset mid-byte
    ticks(3);
    write_word(32'h0000_00C3);
    ticks(10);
    check("r_cs_busy", spi_cs_n, 0);
    rst_n = 1'b0;
    #1;
    check("r_sclk", spi_sclk, 0);
    check("r_cs_n", spi_cs_n, 1);
    check("r_mosi", spi_mosi, 0);
    check("r_full", wfull, 0);
    check("r_empty", rempty, 1);
    tick();
    rst_n = 1'b1;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
